// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: word width, NOP encoding,
// default reset PC, buffer entry layout and credit counter width.
package instruction_fetch_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_INSTR        = 32'h0000_0000;
    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    // Wide enough for outstanding/buffered/to_drop counts up to the maximum DEPTH of 4.
    localparam int CNT_W = 3;

    // One buffer entry: the instruction together with the word address it came from.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instr}. The head is presented
// combinationally; flush empties the buffer and overrides push and pop.
// Push and pop in the same cycle are allowed even when the buffer is full.
module ifetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output logic             not_empty,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty && !flush;
    assign do_push   = push && !flush && ((count < CNT_W'(DEPTH)) || do_pop);

    // Head entry; an empty buffer presents a NOP at PC 0.
    assign head = not_empty ? mem[rd_ptr] : '{pc: '0, instr: NOP_INSTR};

    // Storage array write.
    // NOTE: the data array has no reset; the count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues sequential word-address requests to an
// in-order instruction memory, buffers responses with their PCs and hands
// them to the datapath. A redirect restarts fetch at a new PC and drops every
// response still in flight. Credit: outstanding + buffered + to_drop < DEPTH.
// Optional: define IFETCH_PERF_CNT_EN to add the fetch_count output.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    word_t            fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] to_drop;
    logic [CNT_W-1:0] buffered;
    logic [CNT_W-1:0] outstanding_n;
    logic [CNT_W-1:0] to_drop_n;
    logic [CNT_W:0]   credit_used;
    logic             req_fire;
    logic             resp_legal;
    logic             resp_keep;
    logic             inst_fire;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign credit_used = {1'b0, outstanding} + {1'b0, buffered} + {1'b0, to_drop};

    // Request only while a buffer slot is reserved for every response that can still return.
    assign imem_req_valid = rst_n && (credit_used < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing pending is illegal and ignored.
    assign resp_legal = imem_resp_valid && ((outstanding != '0) || (to_drop != '0));
    assign resp_keep  = resp_legal && (to_drop == '0) && !redirect_valid;

    // Live outstanding requests are the contiguous addresses just below fetch_pc; the oldest owns this response.
    assign push_entry = '{pc: fetch_pc - 32'(outstanding), instr: imem_resp_data};

    assign inst_fire = inst_valid && inst_ready;
    assign inst_data = head.instr;
    assign inst_pc   = head.pc;

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (resp_keep),
        .push_entry (push_entry),
        .pop        (inst_fire),
        .not_empty  (inst_valid),
        .head       (head),
        .count      (buffered)
    );

    // Credit bookkeeping: retire a response, count a new request, and on redirect move everything in flight to to_drop.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        outstanding_n = outstanding;
        to_drop_n     = to_drop;
        if (resp_legal) begin
            if (to_drop != '0) to_drop_n     = to_drop - CNT_W'(1);
            else               outstanding_n = outstanding - CNT_W'(1);
        end
        if (req_fire) outstanding_n = outstanding_n + CNT_W'(1);
        if (redirect_valid) begin
            to_drop_n     = to_drop_n + outstanding_n;
            outstanding_n = '0;
        end
    end

    // PC and credit counter registers; redirect takes priority over sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            to_drop     <= '0;
        end else begin
            outstanding <= outstanding_n;
            to_drop     <= to_drop_n;
            if (redirect_valid) fetch_pc <= redirect_pc;
            else if (req_fire)  fetch_pc <= fetch_pc + 32'd1;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Count instructions handed to the datapath; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         fetch_count <= '0;
        else if (inst_fire) fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. An in-order memory model with
// 1..3 cycle latency returns addr+0x100; a PC-stream scoreboard predicts the
// request addresses and the delivered instruction stream from fetch rules.
// Define IFETCH_PERF_CNT_EN to also exercise fetch_count.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    instruction_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_resp_t;

    int          tests = 0;
    int          fails = 0;
    mem_resp_t   mq[$];
    int          cyc;
    int          last_due;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rdy_rand = 1'b0;
    bit          ir_rand = 1'b0;
    bit          ir_val = 1'b1;
    logic [31:0] exp_req_addr;
    logic [31:0] exp_inst_pc;
    bit          redir_prev;
    int          fires;
    int          fires_since_reset;
    int          accepts;
    int          first_valid_cyc;
    logic        last_req_valid;
    logic [31:0] last_req_addr;
    logic [31:0] fired_pc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle; entered and left at 1 time unit after a rising edge.
    task automatic tick(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
        int lat;
        int due;
        cyc++;
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        inst_ready     = ir_rand  ? 1'($urandom_range(0, 1)) : ir_val;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].data;
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end

        @(negedge clk);
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;
        if (inst_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
        if (redir_prev) check("inst_valid_after_redirect", 32'(inst_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, 32'(fires_since_reset));
`endif
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_req_addr);
            exp_req_addr = exp_req_addr + 32'd1;
            accepts++;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{data: imem_req_addr + 32'h100, due: due});
        end
        check("mem_inflight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
        if (inst_valid && inst_ready) begin
            check("inst_pc", inst_pc, exp_inst_pc);
            check("inst_data", inst_data, exp_inst_pc + 32'h100);
            fired_pc.push_back(inst_pc);
            exp_inst_pc = exp_inst_pc + 32'd1;
            fires++;
            fires_since_reset++;
        end
        if (redir) begin
            exp_inst_pc  = rpc;
            exp_req_addr = rpc;
        end
        redir_prev = redir;

        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check reset outputs, release 1 unit after an edge.
    task automatic do_reset();
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        mq.delete();
        fired_pc.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_req_addr", imem_req_addr, RST_PC);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_fetch_count", fetch_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n             = 1'b1;
        cyc               = 0;
        last_due          = 0;
        redir_prev        = 1'b0;
        fires_since_reset = 0;
        accepts           = 0;
        first_valid_cyc   = 0;
        exp_req_addr      = RST_PC;
        exp_inst_pc       = RST_PC;
    endtask

    initial begin
        int start;
        int budget;

        // Streaming after reset: 1-cycle memory, datapath always ready.
        do_reset();
        lat_min = 1; lat_max = 1; rdy_rand = 1'b0; ir_rand = 1'b0; ir_val = 1'b1;
        tick();
        check("cycle1_req_valid", 32'(last_req_valid), 32'd1);
        check("cycle1_req_addr", last_req_addr, RST_PC);
        repeat (11) tick();
        check("first_inst_valid_cycle", 32'(first_valid_cyc), 32'd3);
        check("first_pc", fired_pc[0], RST_PC);
        check("second_pc", fired_pc[1], RST_PC + 32'd1);
        check("stream_progress", 32'(fires_since_reset >= 6), 32'd1);

        // Datapath stalled for 10 cycles: exactly DEPTH requests, then no more.
        do_reset();
        ir_val = 1'b0;
        repeat (10) tick();
        check("stall_accepts", 32'(accepts), 32'(DEPTH));
        check("stall_req_valid", 32'(last_req_valid), 32'd0);
        ir_val = 1'b1;
        start = fires_since_reset;
        repeat (10) tick();
        check("resume_delivery", 32'(fires_since_reset - start >= DEPTH + 2), 32'd1);

        // Redirect to 0x40 while two requests are outstanding (3-cycle memory).
        do_reset();
        lat_min = 3; lat_max = 3;
        tick();
        tick();
        check("two_outstanding", 32'(mq.size()), 32'd2);
        tick(1'b1, 32'h40);
        fired_pc.delete();
        budget = 0;
        while (fired_pc.size() < 2 && budget < 40) begin
            tick();
            budget++;
        end
        check("redirect_fires", 32'(fired_pc.size() >= 2), 32'd1);
        check("redirect_pc0", fired_pc[0], 32'h40);
        check("redirect_pc1", fired_pc[1], 32'h41);

        // Address wrap at 32'hFFFF_FFFF.
        lat_min = 1; lat_max = 1;
        tick(1'b1, 32'hFFFF_FFFF);
        fired_pc.delete();
        budget = 0;
        while (fired_pc.size() < 2 && budget < 40) begin
            tick();
            budget++;
        end
        check("wrap_fires", 32'(fired_pc.size() >= 2), 32'd1);
        check("wrap_pc0", fired_pc[0], 32'hFFFF_FFFF);
        check("wrap_pc1", fired_pc[1], 32'h0);

        // Random ready/latency/redirect traffic with one mid-flight reset.
        lat_min = 1; lat_max = 3; rdy_rand = 1'b1; ir_rand = 1'b1;
        start = fires;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(0, 15) == 0) tick(1'b1, $urandom);
            else                            tick();
        end
        check("random_progress", 32'(fires - start > 300), 32'd1);

`ifdef IFETCH_PERF_CNT_EN
        // Five handshakes, then reset clears the counter.
        do_reset();
        lat_min = 1; lat_max = 1; rdy_rand = 1'b0; ir_rand = 1'b0; ir_val = 1'b1;
        budget = 0;
        while (fires_since_reset < 5 && budget < 40) begin
            tick();
            budget++;
        end
        ir_val = 1'b0;
        tick();
        check("perf_count_5", fetch_count, 32'd5);
        do_reset();
        check("perf_count_cleared", fetch_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
